thirteen_to_one_mux: RTL and testbench

//   Registered 13-input, 1-bit multiplexer. A 4-bit select picks one of i1..i13.
//   The chosen bit is registered onto y, one clock after select and data are sampled.

---
 rtl/thirteen_to_one_mux.sv | 78 +++++++
 tb/tb_thirteen_to_one_mux.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/thirteen_to_one_mux.sv
// Registered 13:1 single-bit mux with 1-based select; out-of-range codes load DEFAULT_VAL.
// Optional registered out-of-range flag sel_err is built when MUX_SEL_ERR_EN is defined.
module thirteen_to_one_mux #(
  parameter logic RST_VAL     = 1'b0,
  parameter logic DEFAULT_VAL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i1,
  input  logic       i2,
  input  logic       i3,
  input  logic       i4,
  input  logic       i5,
  input  logic       i6,
  input  logic       i7,
  input  logic       i8,
  input  logic       i9,
  input  logic       i10,
  input  logic       i11,
  input  logic       i12,
  input  logic       i13,
  input  logic [3:0] select,
`ifdef MUX_SEL_ERR_EN
  output logic       sel_err,
`endif
  output logic       y
);

  logic y_nxt;
  logic in_range;

  // Codes 0, 14, 15 (and X/Z in simulation) fall through to the default branch.
  always_comb begin
    y_nxt    = DEFAULT_VAL;
    in_range = 1'b1;
    case (select)
      4'd1:    y_nxt = i1;
      4'd2:    y_nxt = i2;
      4'd3:    y_nxt = i3;
      4'd4:    y_nxt = i4;
      4'd5:    y_nxt = i5;
      4'd6:    y_nxt = i6;
      4'd7:    y_nxt = i7;
      4'd8:    y_nxt = i8;
      4'd9:    y_nxt = i9;
      4'd10:   y_nxt = i10;
      4'd11:   y_nxt = i11;
      4'd12:   y_nxt = i12;
      4'd13:   y_nxt = i13;
      default: begin
        y_nxt    = DEFAULT_VAL;
        in_range = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y <= RST_VAL;
    end else begin
      y <= y_nxt;
    end
  end

`ifdef MUX_SEL_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_err <= 1'b0;
    end else begin
      sel_err <= ~in_range;
    end
  end
`else
  logic unused_in_range;
  assign unused_in_range = in_range;
`endif

endmodule

// File: tb/tb_thirteen_to_one_mux.sv
// Self-checking bench for thirteen_to_one_mux: table-driven vectors plus hand-written
// reset, latency and mid-stream reset sequences. sel_err is checked when MUX_SEL_ERR_EN is defined.
module tb_thirteen_to_one_mux;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [12:0] dbus = '0;   // dbus[k-1] drives ik
  logic [3:0]  select = 4'd1;
  logic        y;
`ifdef MUX_SEL_ERR_EN
  logic        sel_err;
`endif

  int checks = 0;
  int errors = 0;

  thirteen_to_one_mux #(.RST_VAL(1'b0), .DEFAULT_VAL(1'b0)) dut (
    .clk    (clk),
    .rst    (rst),
    .i1     (dbus[0]),
    .i2     (dbus[1]),
    .i3     (dbus[2]),
    .i4     (dbus[3]),
    .i5     (dbus[4]),
    .i6     (dbus[5]),
    .i7     (dbus[6]),
    .i8     (dbus[7]),
    .i9     (dbus[8]),
    .i10    (dbus[9]),
    .i11    (dbus[10]),
    .i12    (dbus[11]),
    .i13    (dbus[12]),
    .select (select),
`ifdef MUX_SEL_ERR_EN
    .sel_err(sel_err),
`endif
    .y      (y)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  sel;
    logic [12:0] d;
    logic        exp_y;
    logic        exp_err;
  } vec_t;

  localparam logic [12:0] D  = 13'b0101001101001;
  localparam logic [12:0] DN = 13'b1010110010110;

  vec_t vecs[$];

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [3:0] s, input logic [12:0] d, input logic ey, input logic ee);
    vec_t v;
    v.sel = s; v.d = d; v.exp_y = ey; v.exp_err = ee;
    vecs.push_back(v);
  endtask

  initial begin
    // Stepping select 1..13 over D.
    add(4'd1, D, 1'b1, 1'b0);  add(4'd2, D, 1'b0, 1'b0);  add(4'd3, D, 1'b0, 1'b0);
    add(4'd4, D, 1'b1, 1'b0);  add(4'd5, D, 1'b0, 1'b0);  add(4'd6, D, 1'b1, 1'b0);
    add(4'd7, D, 1'b1, 1'b0);  add(4'd8, D, 1'b0, 1'b0);  add(4'd9, D, 1'b0, 1'b0);
    add(4'd10, D, 1'b1, 1'b0); add(4'd11, D, 1'b0, 1'b0); add(4'd12, D, 1'b1, 1'b0);
    add(4'd13, D, 1'b0, 1'b0);
    // Out-of-range codes, then recovery.
    add(4'd0, D, 1'b0, 1'b1);  add(4'd14, D, 1'b0, 1'b1); add(4'd15, D, 1'b0, 1'b1);
    add(4'd1, D, 1'b1, 1'b0);
    // Inverted vector and all-ones: out-of-range must still give DEFAULT_VAL.
    add(4'd2, DN, 1'b1, 1'b0); add(4'd13, DN, 1'b1, 1'b0); add(4'd1, DN, 1'b0, 1'b0);
    add(4'd0, 13'h1FFF, 1'b0, 1'b1); add(4'd14, 13'h1FFF, 1'b0, 1'b1);
    add(4'd15, 13'h1FFF, 1'b0, 1'b1); add(4'd7, 13'h1FFF, 1'b1, 1'b0);
    add(4'd7, 13'h0000, 1'b0, 1'b0); add(4'd13, 13'h1000, 1'b1, 1'b0);
    add(4'd12, 13'h1000, 1'b0, 1'b0);

    // 1. Reset: asynchronous, no clock edge needed.
    #2;
    chk("reset_async_y", y, 1'b0);
`ifdef MUX_SEL_ERR_EN
    chk("reset_async_err", sel_err, 1'b0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("reset_release_y", y, 1'b0);

    // 2/3. Table-driven vectors.
    foreach (vecs[k]) begin
      @(negedge clk);
      select = vecs[k].sel;
      dbus   = vecs[k].d;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_sel%0d_y", k, vecs[k].sel), y, vecs[k].exp_y);
`ifdef MUX_SEL_ERR_EN
      chk($sformatf("vec%0d_sel%0d_err", k, vecs[k].sel), sel_err, vecs[k].exp_err);
`endif
    end

    // 4. Latency: i4 rises just after edge n, y follows only at edge n+1.
    @(negedge clk);
    select = 4'd4;
    dbus   = 13'h0000;
    @(posedge clk); #1;
    chk("lat_pre_y", y, 1'b0);
    dbus[3] = 1'b1;
    #1;
    chk("lat_no_comb_path", y, 1'b0);
    @(negedge clk);
    chk("lat_mid_cycle", y, 1'b0);
    @(posedge clk); #1;
    chk("lat_after_edge", y, 1'b1);
    @(negedge clk);
    chk("lat_hold_mid", y, 1'b1);

    // 5. Mid-stream reset pulse between edges.
    select = 4'd6;
    dbus   = D;
    @(posedge clk); #1;
    chk("mid_pre_y", y, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_async_drop", y, 1'b0);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_released_no_edge", y, 1'b0);
    @(posedge clk); #1;
    chk("mid_recover", y, 1'b1);

    // Reset held across an edge: nothing may be loaded.
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_held_edge", y, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_held_recover", y, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
